// File: rtl/multi_edge_sync_if.sv
// Bundle of per-channel async inputs, detect modes, acks and event status
// exchanged between the edge-sync block and its consumer.
interface multi_edge_sync_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]   async_in;
    logic [2*CHANNELS-1:0] mode;
    logic [CHANNELS-1:0]   ack;
    logic [CHANNELS-1:0]   level;
    logic [CHANNELS-1:0]   pulse;
    logic [CHANNELS-1:0]   pending;
    logic [CHANNELS-1:0]   missed;

    modport master (
        output async_in, mode, ack,
        input  level, pulse, pending, missed
    );

    modport slave (
        input  async_in, mode, ack,
        output level, pulse, pending, missed
    );
endinterface

// File: rtl/multi_edge_sync.sv
// Multi-channel input synchroniser with per-channel rising/falling edge detect,
// sticky pending/missed event flags and a post-reset arm window.
module multi_edge_sync #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic              clk,
    input logic              reset,
    multi_edge_sync_if.slave bus
);
    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] prev_q;
    logic [CHANNELS-1:0] pulse_q, pulse_d;
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] missed_q, missed_d;
    logic [ARM_W-1:0]    arm_q, arm_d;

    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] evt;
    logic                armed;

    always_comb begin
        level = sync_q[SYNC_STAGES-1];
        rise  = level & ~prev_q;
        fall  = ~level & prev_q;
        armed = (arm_q == ARM_DONE);
        evt   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            evt[i] = armed & ((bus.mode[2*i] & rise[i]) | (bus.mode[2*i+1] & fall[i]));
        end
        // An ack in the same cycle as a new event retires the old one only.
        pulse_d   = evt;
        pending_d = evt | (pending_q & ~bus.ack);
        missed_d  = (evt & pending_q & ~bus.ack) | (missed_q & ~(bus.ack & pending_q));
        arm_d     = armed ? arm_q : arm_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q    <= '0;
            pulse_q   <= '0;
            pending_q <= '0;
            missed_q  <= '0;
            arm_q     <= '0;
        end else begin
            sync_q[0] <= bus.async_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q    <= level;
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
            missed_q  <= missed_d;
            arm_q     <= arm_d;
        end
    end

    assign bus.level   = level;
    assign bus.pulse   = pulse_q;
    assign bus.pending = pending_q;
    assign bus.missed  = missed_q;
endmodule

// File: tb/tb_multi_edge_sync.sv
// Directed bench for multi_edge_sync: a 4-channel/2-stage instance and a
// 1-channel/3-stage instance sharing one clock and reset.
module tb_multi_edge_sync;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    multi_edge_sync_if #(.CHANNELS(4)) bus ();
    multi_edge_sync_if #(.CHANNELS(1)) bus3 ();

    multi_edge_sync #(.CHANNELS(4), .SYNC_STAGES(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    multi_edge_sync #(.CHANNELS(1), .SYNC_STAGES(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.async_in  = '0;
        bus.mode      = 8'h55;
        bus.ack       = '0;
        bus3.async_in = '0;
        bus3.mode     = 2'b01;
        bus3.ack      = '0;
        reset = 1'b0;
        #1;
        n_assert++;
        if ({bus.level, bus.pulse, bus.pending, bus.missed} !== 16'h0) begin
            $display("FAIL reset_outputs: got %h expected 0000",
                     {bus.level, bus.pulse, bus.pending, bus.missed});
            n_fail++;
        end
        tick();
        tick();
        reset = 1'b1;
        repeat (4) tick();
        n_assert++;
        if ({bus.level, bus.pulse, bus.pending, bus.missed, bus3.pulse} !== 17'h0) begin
            $display("FAIL reset_idle: got %h expected 0",
                     {bus.level, bus.pulse, bus.pending, bus.missed, bus3.pulse});
            n_fail++;
        end
    endtask

    task automatic test_rise();
        bus.mode = 8'h55;
        bus.async_in[0] = 1'b1;
        tick();
        n_assert++;
        if (bus.level[0] !== 1'b0) begin
            $display("FAIL rise_level_e1: got %b expected 0", bus.level[0]);
            n_fail++;
        end
        tick();
        n_assert++;
        if (bus.level[0] !== 1'b1 || bus.pulse[0] !== 1'b0) begin
            $display("FAIL rise_e2: level=%b pulse=%b expected level=1 pulse=0",
                     bus.level[0], bus.pulse[0]);
            n_fail++;
        end
        tick();
        n_assert++;
        if (bus.pulse !== 4'b0001 || bus.pending !== 4'b0001) begin
            $display("FAIL rise_e3: pulse=%b pending=%b expected 0001/0001",
                     bus.pulse, bus.pending);
            n_fail++;
        end
        tick();
        n_assert++;
        if (bus.pulse !== 4'b0000 || bus.pending !== 4'b0001) begin
            $display("FAIL rise_e4: pulse=%b pending=%b expected 0000/0001",
                     bus.pulse, bus.pending);
            n_fail++;
        end
        bus.ack = 4'b0001;
        tick();
        bus.ack = 4'b0000;
        n_assert++;
        if (bus.pending !== 4'b0000 || bus.missed !== 4'b0000) begin
            $display("FAIL rise_ack: pending=%b missed=%b expected 0000/0000",
                     bus.pending, bus.missed);
            n_fail++;
        end
    endtask

    task automatic test_both_off();
        int p1_cnt;
        int p1_first;
        int p1_last;
        int p2_cnt;
        logic lvl2_mid;
        p1_cnt   = 0;
        p1_first = -1;
        p1_last  = -1;
        p2_cnt   = 0;
        lvl2_mid = 1'b0;
        bus.mode = 8'h4D;
        bus.async_in[1] = 1'b1;
        bus.async_in[2] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.pulse[1]) begin
                p1_cnt++;
                if (p1_first < 0) p1_first = c;
                p1_last = c;
            end
            if (bus.pulse[2]) p2_cnt++;
            if (c == 5) lvl2_mid = bus.level[2];
            if (c == 9) begin
                bus.async_in[1] = 1'b0;
                bus.async_in[2] = 1'b0;
            end
        end
        n_assert++;
        if (p1_cnt !== 2) begin
            $display("FAIL both_pulse_count: got %0d expected 2", p1_cnt);
            n_fail++;
        end
        n_assert++;
        if (p1_first !== 2 || p1_last !== 12) begin
            $display("FAIL both_pulse_cycles: got %0d,%0d expected 2,12", p1_first, p1_last);
            n_fail++;
        end
        n_assert++;
        if (p2_cnt !== 0 || lvl2_mid !== 1'b1 || bus.level[2] !== 1'b0) begin
            $display("FAIL off_channel: pulses=%0d mid_level=%b end_level=%b expected 0/1/0",
                     p2_cnt, lvl2_mid, bus.level[2]);
            n_fail++;
        end
        n_assert++;
        if (bus.pending[1] !== 1'b1 || bus.missed[1] !== 1'b1 || bus.pending[0] !== 1'b0) begin
            $display("FAIL both_flags: pending=%b missed=%b expected pending[1]=1 missed[1]=1 pending[0]=0",
                     bus.pending, bus.missed);
            n_fail++;
        end
        bus.ack = 4'b0010;
        tick();
        bus.ack = 4'b0000;
        n_assert++;
        if (bus.pending !== 4'b0000 || bus.missed !== 4'b0000) begin
            $display("FAIL both_ack: pending=%b missed=%b expected 0000/0000",
                     bus.pending, bus.missed);
            n_fail++;
        end
    endtask

    task automatic test_missed();
        bus.mode = 8'h57;
        bus.async_in[0] = 1'b0;
        repeat (3) tick();
        n_assert++;
        if (bus.pulse[0] !== 1'b1 || bus.pending[0] !== 1'b1 || bus.missed[0] !== 1'b0) begin
            $display("FAIL missed_first: pulse=%b pending=%b missed=%b expected 1/1/0",
                     bus.pulse[0], bus.pending[0], bus.missed[0]);
            n_fail++;
        end
        tick();
        bus.async_in[0] = 1'b1;
        repeat (3) tick();
        n_assert++;
        if (bus.pending[0] !== 1'b1 || bus.missed[0] !== 1'b1) begin
            $display("FAIL missed_second: pending=%b missed=%b expected 1/1",
                     bus.pending[0], bus.missed[0]);
            n_fail++;
        end
        tick();
        bus.ack = 4'b0001;
        tick();
        bus.ack = 4'b0000;
        n_assert++;
        if (bus.pending[0] !== 1'b0 || bus.missed[0] !== 1'b0) begin
            $display("FAIL missed_ack: pending=%b missed=%b expected 0/0",
                     bus.pending[0], bus.missed[0]);
            n_fail++;
        end
    endtask

    task automatic test_ack_same_cycle();
        bus.async_in[0] = 1'b0;
        repeat (3) tick();
        n_assert++;
        if (bus.pending[0] !== 1'b1) begin
            $display("FAIL same_setup: pending=%b expected 1", bus.pending[0]);
            n_fail++;
        end
        tick();
        bus.async_in[0] = 1'b1;
        tick();
        tick();
        bus.ack = 4'b0001;
        tick();
        bus.ack = 4'b0000;
        n_assert++;
        if (bus.pulse[0] !== 1'b1 || bus.pending[0] !== 1'b1 || bus.missed[0] !== 1'b0) begin
            $display("FAIL same_cycle_ack: pulse=%b pending=%b missed=%b expected 1/1/0",
                     bus.pulse[0], bus.pending[0], bus.missed[0]);
            n_fail++;
        end
        bus.ack = 4'b0001;
        tick();
        bus.ack = 4'b0000;
        n_assert++;
        if (bus.pending[0] !== 1'b0 || bus.missed[0] !== 1'b0) begin
            $display("FAIL same_cleanup: pending=%b missed=%b expected 0/0",
                     bus.pending[0], bus.missed[0]);
            n_fail++;
        end
    endtask

    task automatic test_sync3();
        int extra;
        extra = 0;
        bus3.mode = 2'b01;
        bus3.async_in = 1'b1;
        tick();
        tick();
        n_assert++;
        if (bus3.level !== 1'b0 || bus3.pulse !== 1'b0) begin
            $display("FAIL s3_e2: level=%b pulse=%b expected 0/0", bus3.level, bus3.pulse);
            n_fail++;
        end
        tick();
        n_assert++;
        if (bus3.level !== 1'b1 || bus3.pulse !== 1'b0) begin
            $display("FAIL s3_e3: level=%b pulse=%b expected 1/0", bus3.level, bus3.pulse);
            n_fail++;
        end
        tick();
        n_assert++;
        if (bus3.pulse !== 1'b1 || bus3.pending !== 1'b1) begin
            $display("FAIL s3_e4: pulse=%b pending=%b expected 1/1", bus3.pulse, bus3.pending);
            n_fail++;
        end
        tick();
        bus3.mode = 2'b10;
        repeat (5) begin
            tick();
            if (bus3.pulse !== 1'b0) extra++;
        end
        n_assert++;
        if (extra !== 0 || bus3.missed !== 1'b0) begin
            $display("FAIL s3_mode_switch: pulses=%0d missed=%b expected 0/0", extra, bus3.missed);
            n_fail++;
        end
    endtask

    task automatic test_powerup();
        int bad;
        bad = 0;
        bus.async_in = 4'hF;
        bus.mode     = 8'hFF;
        bus.ack      = 4'h0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_assert++;
        if (bus.level !== 4'h0) begin
            $display("FAIL pwr_level_e1: got %h expected 0", bus.level);
            n_fail++;
        end
        tick();
        n_assert++;
        if (bus.level !== 4'hF) begin
            $display("FAIL pwr_level_e2: got %h expected f", bus.level);
            n_fail++;
        end
        repeat (8) begin
            tick();
            if (bus.pulse !== 4'h0 || bus.pending !== 4'h0) bad++;
        end
        n_assert++;
        if (bad !== 0) begin
            $display("FAIL pwr_no_pulse: got %0d bad cycles expected 0", bad);
            n_fail++;
        end
        bus.async_in = 4'h0;
        repeat (3) tick();
        n_assert++;
        if (bus.pulse !== 4'hF || bus.pending !== 4'hF) begin
            $display("FAIL simul_fall: pulse=%h pending=%h expected f/f", bus.pulse, bus.pending);
            n_fail++;
        end
        tick();
        bus.async_in = 4'hF;
        tick();
        #2;
        reset = 1'b0;
        #1;
        n_assert++;
        if ({bus.level, bus.pulse, bus.pending, bus.missed} !== 16'h0) begin
            $display("FAIL midreset_clear: got %h expected 0000",
                     {bus.level, bus.pulse, bus.pending, bus.missed});
            n_fail++;
        end
        tick();
        tick();
        reset = 1'b1;
        bad = 0;
        repeat (8) begin
            tick();
            if (bus.pulse !== 4'h0 || bus.pending !== 4'h0) bad++;
        end
        n_assert++;
        if (bad !== 0 || bus.level !== 4'hF) begin
            $display("FAIL midreset_release: bad=%0d level=%h expected 0/f", bad, bus.level);
            n_fail++;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        test_reset();
        test_rise();
        test_both_off();
        test_missed();
        test_ack_same_cycle();
        test_sync3();
        test_powerup();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_edge_sync.md
MULTI_EDGE_SYNC -- requirements
Module: multi_edge_sync

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent asynchronous inputs (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flop depth per channel (2..4).
REQ-003 clk  input  1  single clock; all state SHALL be in this domain.
REQ-004 reset  input  1  asynchronous, active-low; SHALL clear all state while low, independent of clk.
REQ-005 async_in  input  CHANNELS  asynchronous levels, one per channel.
REQ-006 mode  input  2*CHANNELS  per-channel detect mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-007 ack  input  CHANNELS  per-channel acknowledge of pending event.
REQ-008 level  output  CHANNELS  synchronised level (last synchroniser stage).
REQ-009 pulse  output  CHANNELS  registered one-cycle event strobe.
REQ-010 pending  output  CHANNELS  sticky event flag, held until ack.
REQ-011 missed  output  CHANNELS  sticky overrun flag.

Function
REQ-012 Each channel SHALL pass async_in through SYNC_STAGES flops; level SHALL equal the last stage.
REQ-013 Each channel SHALL hold prev = level delayed one clk.
REQ-014 Edge detect: rise = level & ~prev, fall = ~level & prev; event = (mode[0] & rise) | (mode[1] & fall), using mode in the same cycle.
REQ-015 pulse SHALL register event: high for exactly one cycle per edge, no pulse for mode 00.
REQ-016 Latency: async_in change stable before clk edge 1 SHALL give level change after edge SYNC_STAGES and pulse high after edge SYNC_STAGES+1.
REQ-017 Input toggles faster than one per 2 clk are not guaranteed to be detected; each detected level change SHALL produce at most one pulse.
REQ-018 A mode change SHALL NOT generate a pulse by itself.
REQ-019 pending SHALL set on the edge pulse is set; SHALL clear on ack when no new event occurs in the same cycle.
REQ-020 Event and ack in the same cycle: pending SHALL remain 1 and missed SHALL NOT set (old event acknowledged, new one pending).
REQ-021 Event while pending=1 and ack=0: missed SHALL set and pending SHALL stay 1.
REQ-022 missed SHALL clear on ack unless REQ-021 holds in that cycle; ack with pending=0 SHALL have no effect.
REQ-023 Channels SHALL be fully independent; simultaneous events on any set of channels SHALL each be reported.
REQ-024 A global arm counter (width clog2(SYNC_STAGES+2)) SHALL suppress events for the first SYNC_STAGES+1 clk edges after reset release; prev SHALL still track level during that window.

Reset
REQ-025 reset low SHALL asynchronously force synchroniser stages, prev, level, pulse, pending, missed and arm counter to 0.
REQ-026 Input held high through reset release SHALL NOT produce a pulse (arm window, REQ-024); level SHALL go high after SYNC_STAGES edges.
REQ-027 reset asserted mid-operation SHALL discard in-flight edges; no pulse SHALL appear after release for an edge sampled before reset.
REQ-028 Release of reset SHALL be treated as asynchronous to clk only for assertion; deassertion is externally synchronised to clk.

Verification
REQ-029 CHANNELS=4, SYNC_STAGES=2, mode=all 01, ch0 rises after arm -> level[0] high after edge 2, pulse[0] high exactly one cycle after edge 3, pending[0]=1.
REQ-030 mode ch1=11, ch1 high 10 cycles then low -> two single-cycle pulses 10 cycles apart; mode ch2=00 same stimulus -> no pulse, level[2] still follows.
REQ-031 ch0 pending, second edge without ack -> missed[0]=1, pending[0]=1; ack one cycle -> both 0 next cycle.
REQ-032 ack asserted in the exact cycle of a new event -> pending stays 1, missed stays 0.
REQ-033 async_in=4'hF held through reset release -> no pulse ever, level=4'hF after 2 edges; then reset pulsed low mid-edge -> all outputs 0 immediately, no post-release pulse.
REQ-034 SYNC_STAGES=3, CHANNELS=1 -> pulse after edge 4 from input change; mode switched 01->10 while level static -> no pulse.
